// File: rtl/pwm_motor_pkg.sv
// pwm_motor_pkg
//   Shared types and helpers for the PWM motor driver.
//   - chan_state_t : per-wheel channel state (RUN / DEAD)
//   - sat_t        : {dir, duty} result of sat_mag()
//   - sat_mag()    : splits a signed wheel command into direction and a
//                    magnitude saturated to the PWM duty range.
package pwm_motor_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        DEAD = 1'b1
    } chan_state_t;

    // Wide enough for any mixing width used by the driver.
    localparam int unsigned SAT_W = 32;

    typedef struct packed {
        logic             dir;
        logic [SAT_W-1:0] duty;
    } sat_t;

    // dir = 1 for a negative raw value; duty = min(|raw|, 2**duty_width-1).
    // raw == 0 yields forward with duty 0.
    function automatic sat_t sat_mag(input logic signed [SAT_W-1:0] raw,
                                     input int unsigned             duty_width);
        sat_t             r;
        logic [SAT_W-1:0] mag;
        logic [SAT_W-1:0] max_duty;
        mag      = raw[SAT_W-1] ? SAT_W'(-raw) : SAT_W'(raw);
        max_duty = (SAT_W'(1) << duty_width) - SAT_W'(1);
        r.dir    = raw[SAT_W-1];
        r.duty   = (mag > max_duty) ? max_duty : mag;
        return r;
    endfunction

endpackage

// File: rtl/pwm_motor_driver_channel.sv
// pwm_channel
//   One wheel of the motor driver: run/dead-time FSM, latched duty and
//   direction, and the PWM compare against the shared period counter.
//   Ports:
//     clk, reset      system clock, async active-high reset
//     enable_q        synchronised enable; low forces pwm low
//     boundary        one-cycle strobe at the last tick of a PWM period
//     pwm_cnt         shared PWM period counter
//     req_dir/duty    requested direction/duty, sampled at boundary
//     pwm, dir        H-bridge outputs for this wheel
module pwm_channel
    import pwm_motor_pkg::*;
#(
    parameter int unsigned DUTY_WIDTH   = 10,
    parameter int unsigned DEAD_PERIODS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_q,
    input  logic                  boundary,
    input  logic [DUTY_WIDTH-1:0] pwm_cnt,
    input  logic                  req_dir,
    input  logic [DUTY_WIDTH-1:0] req_duty,
    output logic                  pwm,
    output logic                  dir
);

    localparam int unsigned DC_W = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;

    chan_state_t           state;
    logic [DUTY_WIDTH-1:0] duty;
    logic [DC_W-1:0]       dead_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            duty     <= '0;
            dir      <= 1'b0;
            dead_cnt <= '0;
            pwm      <= 1'b0;
        end else begin
            pwm <= enable_q && (pwm_cnt < duty);
            if (boundary) begin
                case (state)
                    RUN: begin
                        if (req_dir == dir) begin
                            duty <= req_duty;
                        end else begin
                            // Hold the wheel off before reversing; dir flips
                            // only when the dead-time has fully elapsed.
                            duty     <= '0;
                            dead_cnt <= DC_W'(DEAD_PERIODS - 1);
                            state    <= DEAD;
                        end
                    end
                    DEAD: begin
                        if (dead_cnt != '0) begin
                            dead_cnt <= dead_cnt - 1'b1;
                        end else begin
                            dir   <= req_dir;
                            duty  <= req_duty;
                            state <= RUN;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: rtl/pwm_motor_driver.sv
// pwm_motor_driver
//   Mixes a signed PID correction with a base speed into left/right wheel
//   duty cycles and drives one PWM + direction pin per wheel.
//   Ports:
//     clk, reset          system clock, async active-high reset
//     enable              1 = drive motors, 0 = both PWM outputs low
//     control_signal_in   signed fixed-point PID correction (+ steers right)
//     base_speed          nominal forward duty
//     pwm_left/right      H-bridge PWM outputs
//     dir_left/right      direction outputs, 0 = forward
//     period_start        one-cycle pulse aligned with pwm_cnt == 0
module pwm_motor_driver
    import pwm_motor_pkg::*;
#(
    parameter int unsigned PID_OUT_WIDTH = 16,
    parameter int unsigned CTRL_SHIFT    = 8,
    parameter int unsigned DUTY_WIDTH    = 10,
    parameter int unsigned PRESCALE      = 6,
    parameter int unsigned DEAD_PERIODS  = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic signed [PID_OUT_WIDTH-1:0] control_signal_in,
    input  logic        [DUTY_WIDTH-1:0]    base_speed,
    output logic                            pwm_left,
    output logic                            pwm_right,
    output logic                            dir_left,
    output logic                            dir_right,
    output logic                            period_start
);

    localparam int unsigned PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned RAW_W =
        ((DUTY_WIDTH > PID_OUT_WIDTH) ? DUTY_WIDTH : PID_OUT_WIDTH) + 2;

    logic [PS_W-1:0]       ps_cnt;
    logic [DUTY_WIDTH-1:0] pwm_cnt;
    logic                  tick;
    logic                  boundary;
    logic                  enable_q;

    assign tick     = (ps_cnt == PS_W'(PRESCALE - 1));
    assign boundary = tick && (&pwm_cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps_cnt       <= '0;
            pwm_cnt      <= '0;
            period_start <= 1'b0;
            enable_q     <= 1'b0;
        end else begin
            ps_cnt       <= tick ? '0 : ps_cnt + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            period_start <= boundary;
            enable_q     <= enable;
        end
    end

    // Mixing: sign-extend first so the arithmetic shift floors toward -inf.
    logic signed [RAW_W-1:0] ctrl_ext;
    logic signed [RAW_W-1:0] corr;
    logic signed [RAW_W-1:0] base_ext;
    logic signed [RAW_W-1:0] left_raw;
    logic signed [RAW_W-1:0] right_raw;

    assign ctrl_ext  = RAW_W'(control_signal_in);
    assign corr      = ctrl_ext >>> CTRL_SHIFT;
    assign base_ext  = RAW_W'(base_speed);
    assign left_raw  = base_ext + corr;
    assign right_raw = base_ext - corr;

    sat_t left_sat;
    sat_t right_sat;
    logic sat_unused;

    assign left_sat   = sat_mag(SAT_W'(left_raw),  DUTY_WIDTH);
    assign right_sat  = sat_mag(SAT_W'(right_raw), DUTY_WIDTH);
    // Upper duty bits are always zero after saturation.
    assign sat_unused = ^{left_sat.duty[SAT_W-1:DUTY_WIDTH],
                          right_sat.duty[SAT_W-1:DUTY_WIDTH]};

    pwm_channel #(
        .DUTY_WIDTH   (DUTY_WIDTH),
        .DEAD_PERIODS (DEAD_PERIODS)
    ) u_left (
        .clk      (clk),
        .reset    (reset),
        .enable_q (enable_q),
        .boundary (boundary),
        .pwm_cnt  (pwm_cnt),
        .req_dir  (left_sat.dir),
        .req_duty (left_sat.duty[DUTY_WIDTH-1:0]),
        .pwm      (pwm_left),
        .dir      (dir_left)
    );

    pwm_channel #(
        .DUTY_WIDTH   (DUTY_WIDTH),
        .DEAD_PERIODS (DEAD_PERIODS)
    ) u_right (
        .clk      (clk),
        .reset    (reset),
        .enable_q (enable_q),
        .boundary (boundary),
        .pwm_cnt  (pwm_cnt),
        .req_dir  (right_sat.dir),
        .req_duty (right_sat.duty[DUTY_WIDTH-1:0]),
        .pwm      (pwm_right),
        .dir      (dir_right)
    );

endmodule

// File: tb/tb_pwm_motor_driver.sv
// tb_pwm_motor_driver
//   Directed bench for pwm_motor_driver with PRESCALE=1, DUTY_WIDTH=4,
//   CTRL_SHIFT=8, DEAD_PERIODS=2 (16-clk PWM period).
module tb_pwm_motor_driver;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic signed [15:0] control_signal_in;
    logic        [3:0]  base_speed;
    logic               pwm_left, pwm_right, dir_left, dir_right, period_start;

    int n_vec = 0;
    int n_err = 0;
    int hl, hr, dl, dr;

    always #5 clk = ~clk;

    pwm_motor_driver #(
        .PID_OUT_WIDTH (16),
        .CTRL_SHIFT    (8),
        .DUTY_WIDTH    (4),
        .PRESCALE      (1),
        .DEAD_PERIODS  (2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .control_signal_in (control_signal_in),
        .base_speed        (base_speed),
        .pwm_left          (pwm_left),
        .pwm_right         (pwm_right),
        .dir_left          (dir_left),
        .dir_right         (dir_right),
        .period_start      (period_start)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Apply new mixing inputs and step off the current cycle so the next
    // period_start is guaranteed to have sampled them.
    task automatic set_inputs(input logic [3:0] base, input logic [15:0] ctrl);
        base_speed        = base;
        control_signal_in = ctrl;
        @(negedge clk);
    endtask

    // Wait (bounded) for period_start, then count pwm highs over the
    // following 16 clks; dirs sampled at the first of them.
    task automatic measure(input string tag, output int l, output int r,
                           output int dlo, output int dro);
        int w;
        w = 0;
        while (!period_start && w < 64) begin
            @(negedge clk);
            w++;
        end
        chk({tag, ":ps_seen"}, int'(period_start), 1);
        l = 0; r = 0; dlo = 0; dro = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            l += int'(pwm_left);
            r += int'(pwm_right);
            if (i == 0) begin
                dlo = int'(dir_left);
                dro = int'(dir_right);
            end
        end
    endtask

    // Count clks from reset release to first period_start; pwm highs seen
    // before it are returned in pre.
    task automatic first_ps(output int k, output int pre);
        pre = 0;
        k   = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (period_start) begin
                k = i;
                break;
            end
            pre += int'(pwm_left) + int'(pwm_right);
        end
    endtask

    int lat, pre;

    initial begin
        reset = 1'b1; enable = 1'b0; control_signal_in = '0; base_speed = '0;
        @(negedge clk); @(negedge clk);
        chk("reset_outputs", int'({pwm_left, pwm_right, dir_left, dir_right, period_start}), 0);

        // Straight: duty 0 holds until the first boundary.
        base_speed = 4'd8; enable = 1'b1;
        reset = 1'b0;
        first_ps(lat, pre);
        chk("first_ps_latency", lat, 16);
        chk("pre_boundary_highs", pre, 0);
        measure("straight", hl, hr, dl, dr);
        chk("straight_left", hl, 8);
        chk("straight_right", hr, 8);
        chk("straight_dirs", dl + dr, 0);

        // -0.5 floors to -1.
        set_inputs(4'd8, 16'hFF80);
        measure("negfrac", hl, hr, dl, dr);
        chk("negfrac_left", hl, 7);
        chk("negfrac_right", hr, 9);

        set_inputs(4'd8, 16'h0300);
        measure("steer3", hl, hr, dl, dr);
        chk("steer3_left", hl, 11);
        chk("steer3_right", hr, 5);
        chk("steer3_dirs", dl + dr, 0);

        // +10: left saturates, right reverses after two dead periods.
        set_inputs(4'd8, 16'h0A00);
        measure("dead0", hl, hr, dl, dr);
        chk("dead0_left_sat", hl, 15);
        chk("dead0_right", hr, 0);
        chk("dead0_dir_right", dr, 0);
        measure("dead1", hl, hr, dl, dr);
        chk("dead1_right", hr, 0);
        chk("dead1_dir_right", dr, 0);
        measure("dead2", hl, hr, dl, dr);
        chk("dead2_right", hr, 2);
        chk("dead2_dir_right", dr, 1);
        chk("dead2_left", hl, 15);

        // Request forward, then flip back during dead-time.
        set_inputs(4'd8, 16'h0000);
        measure("flip0", hl, hr, dl, dr);
        chk("flip0_left", hl, 8);
        chk("flip0_right", hr, 0);
        chk("flip0_dir_right", dr, 1);
        control_signal_in = 16'h0A00;
        measure("flip1", hl, hr, dl, dr);
        chk("flip1_right", hr, 0);
        chk("flip1_dir_right", dr, 1);
        measure("flip2", hl, hr, dl, dr);
        chk("flip2_right", hr, 2);
        chk("flip2_dir_right", dr, 1);
        chk("flip2_left", hl, 15);

        // Enable drop / restore mid-period (left duty 15, right duty 2).
        repeat (3) @(negedge clk);
        chk("en_pre_left", int'(pwm_left), 1);
        enable = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("en_off_left", int'(pwm_left), 0);
        @(negedge clk);
        chk("en_off_dir_right", int'(dir_right), 1);
        enable = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("en_on_left", int'(pwm_left), 1);
        chk("en_on_right", int'(pwm_right), 0);

        // Mid-operation reset with pwm_left high and dir_right set.
        chk("prereset_state", int'({pwm_left, dir_right}), 3);
        reset = 1'b1;
        #1;
        chk("midreset_outputs", int'({pwm_left, pwm_right, dir_left, dir_right, period_start}), 0);
        control_signal_in = 16'h0000;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        first_ps(lat, pre);
        chk("midreset_ps_latency", lat, 16);
        measure("postreset", hl, hr, dl, dr);
        chk("postreset_left", hl, 8);
        chk("postreset_right", hr, 8);
        chk("postreset_dirs", dl + dr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_motor_driver.md
Name: pwm_motor_driver

Overview:
- Consumer end of the PID control path: takes the signed control_signal from the PID block and a base speed, and mixes them into left/right wheel duty cycles.
- Generates one PWM output and one direction output per wheel for the H-bridge.
- Duty updates happen only on PWM period boundaries.
- A reversing wheel is held off for a dead-time before its direction pin flips.

Parameters:
- PID_OUT_WIDTH, 16: width of the signed control input. Q(PID_OUT_WIDTH-CTRL_SHIFT).CTRL_SHIFT fixed-point.
- CTRL_SHIFT, 8: arithmetic right shift applied to the control input to drop fraction bits.
- DUTY_WIDTH, 10: PWM counter and duty width. Period is 2**DUTY_WIDTH ticks.
- PRESCALE, 6: clk cycles per PWM tick, >=1. At 125 MHz this gives about 20.3 kHz PWM.
- DEAD_PERIODS, 2: number of full PWM periods a wheel is forced low on a direction change, >=1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = drive motors. 0 = both PWM outputs low.
- control_signal_in  in  PID_OUT_WIDTH (signed)  PID correction. Positive steers right.
- base_speed  in  DUTY_WIDTH (unsigned)  nominal forward duty.
- pwm_left  out  1  left H-bridge PWM.
- pwm_right  out  1  right H-bridge PWM.
- dir_left  out  1  left direction, 0 = forward.
- dir_right  out  1  right direction, 0 = forward.
- period_start  out  1  one-cycle pulse on each PWM period boundary.

Behaviour:
- Reset (async):
  - Prescale counter and PWM counter = 0.
  - All outputs 0.
  - Both channels in RUN with latched duty 0, direction forward.
- Tick generation:
  - Prescale counter counts 0..PRESCALE-1.
  - tick = 1 when it is at PRESCALE-1.
  - pwm_cnt increments on tick and wraps from 2**DUTY_WIDTH-1 to 0.
- Boundary:
  - boundary = tick && pwm_cnt == all-ones.
  - period_start is registered: it is high in the cycle after boundary, aligned with pwm_cnt == 0.
- Mixing (combinational, sampled at boundary):
  - corr = control_signal_in >>> CTRL_SHIFT (arithmetic shift).
  - left_raw = base_speed + corr; right_raw = base_speed - corr.
  - Width is max(DUTY_WIDTH, PID_OUT_WIDTH) + 2 bits, signed, so no overflow is possible.
- Per-channel magnitude and sign:
  - req_dir = sign(raw).
  - req_duty = min(|raw|, 2**DUTY_WIDTH-1), i.e. saturating.
  - raw == 0 gives forward with duty 0.
- Channel FSM, evaluated only at boundary:
  - RUN, req_dir == dir: latch duty = req_duty.
  - RUN, req_dir != dir: latch duty = 0, dead_cnt = DEAD_PERIODS-1, go to DEAD. dir is unchanged.
  - DEAD, dead_cnt != 0: decrement dead_cnt, duty stays 0.
  - DEAD, dead_cnt == 0: dir <= req_dir as sampled at that boundary, duty <= req_duty, go to RUN.
  - A request that flips back during DEAD is still honoured; the dead-time is never shortened.
- PWM output:
  - pwm = enable_q && (pwm_cnt < duty), registered (one clk of latency after pwm_cnt).
  - Duty 0 gives constant low; max duty is high for (2**DUTY_WIDTH-1) of 2**DUTY_WIDTH ticks.
- enable:
  - Synchronised into enable_q (1 flop).
  - Low forces both pwm low on the next clk, independent of the boundary.
  - The FSMs, counters and dir keep running.
- Inputs between boundaries are ignored. Latency from an input change to a duty change is up to one PWM period plus 1 clk.
- Mid-operation reset returns everything to reset values immediately. The FSMs restart in RUN/forward with no dead-time.

Decomposition:
- Package pwm_motor_pkg holds:
  - chan_state_t enum {RUN, DEAD};
  - the function sat_mag() returning {dir, duty} from a signed raw value.
- Sub-module pwm_channel holds one wheel: FSM, duty/dir latch and compare. It is instantiated twice.
- The top level owns the prescaler, pwm_cnt, mixing and enable sync.

Test Plan (PRESCALE=1, DUTY_WIDTH=4, CTRL_SHIFT=8, DEAD_PERIODS=2 unless noted):
- Reset: assert reset mid-period with pwm high -> all outputs 0 the same cycle. After release, the first period_start comes 16 clks later.
- Straight: base=8, control=0, enable=1 -> both pwm high 8 of every 16 clks, dirs 0. The change takes effect only at the next period_start.
- Steer: base=8, control=0x0300 (+3) -> left duty 11, right duty 5. With control=0x0A00 (+10): left saturates at 15, right = -2 gives dir_right flip after dead-time.
- Dead-time: from right forward duty 5, step to raw -2 -> pwm_right low for exactly 2 full periods. dir_right goes to 1 at the 3rd boundary, then duty 2.
- Negative fraction: control=0xFF80 (-0.5) -> corr = -1 (arithmetic floor), left duty 7, right duty 9 with base 8.
- Enable: drop enable mid-period -> pwm low within 2 clks. Raise it again -> PWM resumes at the current duty without waiting for a boundary.
